// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencer that owns the 8-bit ALU datapath.
//
// Accepts commands over a valid/ready handshake. A load command writes the
// operand straight into the accumulator. Any other command applies the
// selected ALU operation (acc op operand) count+1 times, feeding the result
// back as operand A each cycle. When the command completes, the accumulator
// and a sticky carry are offered over a second valid/ready handshake.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clr                synchronous clear (acc, carry, FSM); highest priority
//   cmd_valid/ready    command handshake
//   cmd_load           1 = load cmd_operand into acc, no ALU use
//   cmd_sel            ALU operation select
//   cmd_operand        ALU operand B, or load value
//   cmd_count          extra repetitions (op applied count+1 times)
//   alu_a/b/sel        registered drive to the ALU
//   alu_result/cout    combinational ALU outputs
//   res_valid/ready    result handshake
//   res_data           accumulator value
//   res_carry          OR of alu_cout over all iterations of the last command
//   busy               controller is executing or holding a result
module alu_seq_ctrl #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_sel,
  input  logic [W-1:0]     cmd_operand,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_sel,
  input  logic [W-1:0]     alu_result,
  input  logic             alu_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic             res_carry,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q;
  logic [W-1:0]     op_b_q;
  logic [2:0]       op_sel_q;
  logic [CNT_W-1:0] remaining_q;
  logic             carry_q;
  logic             accept;

  // Next-state logic; clr overrides every transition, including an accept.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = cmd_load ? DONE : EXEC;
        end
      end
      EXEC: begin
        if (remaining_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      op_b_q      <= '0;
      op_sel_q    <= '0;
      remaining_q <= '0;
      carry_q     <= 1'b0;
    end else if (clr) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      op_b_q      <= cmd_operand;
      op_sel_q    <= cmd_sel;
      remaining_q <= cmd_count;
      carry_q     <= 1'b0;
      if (cmd_load) begin
        acc_q <= cmd_operand;
      end
    end else if (state_q == EXEC) begin
      acc_q   <= alu_result;
      carry_q <= carry_q | alu_cout;
      if (remaining_q != '0) begin
        remaining_q <= remaining_q - CNT_W'(1);
      end
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_data  = acc_q;
  assign res_carry = carry_q;
  assign alu_a     = acc_q;
  assign alu_b     = op_b_q;
  assign alu_sel   = op_sel_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_sel;
  logic [7:0] cmd_operand;
  logic [3:0] cmd_count;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_cout;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_carry;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  // Expected {carry, data} per result, pushed when a command is driven.
  logic [8:0] exp_q[$];

  typedef struct {
    logic       ld;
    logic [2:0] sel;
    logic [7:0] opnd;
    logic [3:0] cnt;
    logic [7:0] exp_data;
    logic       exp_carry;
    int         exp_lat;
  } cmd_t;

  cmd_t tbl[11];

  alu_seq_ctrl #(.W(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_load   (cmd_load),
    .cmd_sel    (cmd_sel),
    .cmd_operand(cmd_operand),
    .cmd_count  (cmd_count),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_carry  (res_carry),
    .busy       (busy)
  );

  // Behavioural ALU: 000 = ADD (cout = bit 8), 001 = SUB (cout = borrow).
  always_comb begin
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_sel)
      3'b000: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: begin
        alu_result = alu_a - alu_b;
        alu_cout   = (alu_a < alu_b);
      end
      default: alu_result = alu_a & alu_b;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_unexpected: got result 0x%0h with empty scoreboard, required none", tag, res_data);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, 32'(res_data), 32'(e[7:0]));
      check({tag, "_carry"}, 32'(res_carry), 32'(e[8]));
    end
  endtask

  // Drives one command with res_ready held high and follows it to IDLE.
  task automatic run_cmd(input cmd_t c, input string tag);
    int lat;
    int busy_n;
    bit seen;
    exp_q.push_back({c.exp_carry, c.exp_data});
    @(negedge clk);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_load    = c.ld;
    cmd_sel     = c.sel;
    cmd_operand = c.opnd;
    cmd_count   = c.cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat    = 1;
    busy_n = 0;
    seen   = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (busy) busy_n++;
      if (res_valid && !seen) begin
        seen = 1'b1;
        check({tag, "_latency"}, 32'(lat), 32'(c.exp_lat));
        pop_check(tag);
      end else if (busy && !res_valid) begin
        check({tag, "_alu_b"}, 32'(alu_b), 32'(c.opnd));
        check({tag, "_alu_sel"}, 32'(alu_sel), 32'(c.sel));
      end
      if (!busy) break;
      @(negedge clk);
      if (!seen) lat++;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(c.exp_lat));
  endtask

  initial begin
    cmd_t c;
    tbl[0]  = '{1'b1, 3'b000, 8'h05, 4'd0,  8'h05, 1'b0, 1};
    tbl[1]  = '{1'b0, 3'b000, 8'h03, 4'd0,  8'h08, 1'b0, 2};
    tbl[2]  = '{1'b1, 3'b000, 8'h00, 4'd0,  8'h00, 1'b0, 1};
    tbl[3]  = '{1'b0, 3'b000, 8'h07, 4'd4,  8'h23, 1'b0, 6};
    tbl[4]  = '{1'b1, 3'b000, 8'hF0, 4'd0,  8'hF0, 1'b0, 1};
    tbl[5]  = '{1'b0, 3'b000, 8'h20, 4'd1,  8'h30, 1'b1, 3};
    tbl[6]  = '{1'b0, 3'b001, 8'h10, 4'd0,  8'h20, 1'b0, 2};
    tbl[7]  = '{1'b0, 3'b001, 8'h30, 4'd0,  8'hF0, 1'b1, 2};
    tbl[8]  = '{1'b0, 3'b000, 8'hFF, 4'd15, 8'hE0, 1'b1, 17};
    tbl[9]  = '{1'b1, 3'b000, 8'h01, 4'd0,  8'h01, 1'b0, 1};
    tbl[10] = '{1'b0, 3'b000, 8'h01, 4'd0,  8'h02, 1'b0, 2};

    rst_n       = 1'b1;
    clr         = 1'b0;
    cmd_valid   = 1'b0;
    cmd_load    = 1'b0;
    cmd_sel     = '0;
    cmd_operand = '0;
    cmd_count   = '0;
    res_ready   = 1'b1;

    #3 rst_n = 1'b0;
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_carry", 32'(res_carry), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_cmd(tbl[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held while res_ready=0, cmd_valid pulses ignored.
    res_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h42});
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_load    = 1'b1;
    cmd_operand = 8'h42;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_data", 32'(res_data), 32'h42);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      cmd_valid   = (i % 2 == 0);
      cmd_load    = 1'b1;
      cmd_operand = 8'h99;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("bp_still_valid", 32'(res_valid), 32'd1);
    pop_check("bp");
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_valid", 32'(res_valid), 32'd0);
    check("bp_rel_busy", 32'(busy), 32'd0);
    check("bp_rel_ready", 32'(cmd_ready), 32'd1);
    check("bp_rel_data", 32'(res_data), 32'h42);

    // clr together with an accept in IDLE: command dropped, acc cleared.
    clr         = 1'b1;
    cmd_valid   = 1'b1;
    cmd_load    = 1'b1;
    cmd_operand = 8'h77;
    @(negedge clk);
    clr       = 1'b0;
    cmd_valid = 1'b0;
    check("clr_idle_busy", 32'(busy), 32'd0);
    check("clr_idle_ready", 32'(cmd_ready), 32'd1);
    check("clr_idle_valid", 32'(res_valid), 32'd0);
    check("clr_idle_data", 32'(res_data), 32'd0);
    @(negedge clk);
    check("clr_idle_busy2", 32'(busy), 32'd0);

    // clr in the second EXEC cycle of a count-3 command.
    c = '{1'b1, 3'b000, 8'h10, 4'd0, 8'h10, 1'b0, 1};
    run_cmd(c, "clr_pre");
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_load    = 1'b0;
    cmd_sel     = 3'b000;
    cmd_operand = 8'h01;
    cmd_count   = 4'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("clr_exec1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("clr_exec2_acc", 32'(res_data), 32'h11);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_exec_busy", 32'(busy), 32'd0);
    check("clr_exec_valid", 32'(res_valid), 32'd0);
    check("clr_exec_data", 32'(res_data), 32'd0);
    check("clr_exec_carry", 32'(res_carry), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("clr_exec_no_result", 32'(res_valid), 32'd0);
    end

    // Asynchronous reset in the middle of EXEC.
    run_cmd(c, "rst_pre");
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_load    = 1'b0;
    cmd_sel     = 3'b001;
    cmd_operand = 8'h01;
    cmd_count   = 4'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rstx_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstx_busy", 32'(busy), 32'd0);
    check("rstx_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rstx_valid", 32'(res_valid), 32'd0);
    check("rstx_data", 32'(res_data), 32'd0);
    check("rstx_alu_b", 32'(alu_b), 32'd0);
    check("rstx_alu_sel", 32'(alu_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rstx_no_result", 32'(res_valid), 32'd0);
    end
    check("rstx_post_ready", 32'(cmd_ready), 32'd1);
    check("rstx_post_data", 32'(res_data), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencer that owns the 8-bit ALU datapath (alu_8bit) and drives its A, B and sel inputs.
- Accepts commands over a valid/ready handshake and keeps an accumulator fed back as ALU operand A.
- Can repeat one operation N+1 times, for example repeated add used as a multiply.
- Returns the accumulator and a sticky carry over a second valid/ready handshake. Sits between the tile I/O decode and the ALU.

Parameters:
W, 8, datapath width; matches ALU A/B/Result width.
CNT_W, 4, width of the repeat-count field.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear: acc=0, carry=0, FSM to IDLE
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_load  input  1  1 = load operand into acc, no ALU use
cmd_sel  input  3  ALU operation select
cmd_operand  input  W  ALU operand B, or load value
cmd_count  input  CNT_W  extra repetitions; op is applied count+1 times
alu_a  output  W  to ALU A; always equals acc
alu_b  output  W  to ALU B; latched operand
alu_sel  output  3  to ALU sel; latched select
alu_result  input  W  from ALU Result, combinational
alu_cout  input  1  from ALU Cout
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_data  output  W  accumulator value
res_carry  output  1  OR of alu_cout over all iterations of the last command
busy  output  1  high in EXEC or DONE

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; acc, op_b, op_sel, remaining and carry all 0.
  - Outputs: cmd_ready=1, res_valid=0, busy=0, res_data=0, res_carry=0, alu_a=0, alu_b=0, alu_sel=0.
- States: IDLE, EXEC, DONE. Encoding is free.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready, latch op_b=cmd_operand, op_sel=cmd_sel, remaining=cmd_count.
  - If cmd_load=1: acc=cmd_operand, carry=0, next state DONE.
  - Else: carry=0, next state EXEC.
- EXEC:
  - Each cycle: acc<=alu_result, carry<=carry|alu_cout.
  - If remaining==0, go to DONE; else remaining-=1.
  - A command with count=N occupies exactly N+1 EXEC cycles.
  - alu_a, alu_b and alu_sel are stable registered values throughout EXEC.
- DONE:
  - res_valid=1; res_data=acc, res_carry=carry, both held stable while res_valid=1 and res_ready=0.
  - On res_ready=1, go to IDLE (res_valid drops the next cycle).
  - Latency from accept to res_valid: load = 1 cycle; op = N+2 cycles.
- cmd_ready=0 in EXEC and DONE. cmd_valid is ignored there; the command is not queued.
- acc persists across commands and is cleared only by reset or clr. Chained commands therefore operate on the previous result.
- Arithmetic: acc wraps modulo 2^W exactly as the ALU returns it. The controller adds no saturation.
- clr has priority over everything, including a simultaneous accept or res_ready. Next cycle: IDLE, acc=0, carry=0, res_valid=0. clr in mid-EXEC aborts the command and produces no result.
- Async reset mid-operation aborts immediately; no result is emitted after release.
- busy = (state != IDLE).
- alu_sel and alu_b hold their last latched values in IDLE. The ALU is never observed by the controller outside EXEC.

Test Plan:
Bench uses a behavioural ALU with sel 000 = ADD (cout = bit 8) and 001 = SUB.
- Reset: assert rst_n=0 mid-EXEC -> outputs go to reset values asynchronously; after release cmd_ready=1, res_valid=0, res_data=0.
- Load then add: load 0x05, res_ready=1; then ADD operand 0x03, count 0 -> res_data=0x08, res_carry=0, res_valid exactly 2 cycles after accept.
- Repeat multiply: load 0x00; ADD operand 0x07, count 4 -> EXEC 5 cycles, res_data=0x23 (35), res_carry=0, busy high 6 cycles.
- Wrap and sticky carry: load 0xF0; ADD 0x20, count 1 -> iterations 0x10 (cout=1) then 0x30 (cout=0) -> res_data=0x30, res_carry=1.
- Backpressure and ignored commands: hold res_ready=0 for 5 cycles in DONE while pulsing cmd_valid -> res_data stable, cmd_ready=0, no command accepted; release -> IDLE next cycle.
- clr priority: assert clr in the same cycle as cmd_valid in IDLE, and separately in the 2nd EXEC cycle of count 3 -> no accept, no res_valid, acc=0, state IDLE next cycle.
